// File: rtl/alu_sched_pkg.sv
// Shared opcode, CCR and FSM definitions for the ALU issue scheduler.
// Optional round-robin arbitration is enabled with ALU_SCHED_ROUND_ROBIN_EN.
package alu_sched_pkg;

  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_ADD  = 1;
  localparam int unsigned OP_SUB  = 2;
  localparam int unsigned OP_AND  = 3;
  localparam int unsigned OP_OR   = 4;
  localparam int unsigned OP_XOR  = 5;
  localparam int unsigned OP_NOT  = 6;
  localparam int unsigned OP_MOV  = 7;
  localparam int unsigned OP_CMP  = 8;
  localparam int unsigned OP_SHL  = 9;
  localparam int unsigned OP_SHR  = 10;
  localparam int unsigned OP_ROR  = 11;
  localparam int unsigned OP_ROL  = 12;
  localparam int unsigned OP_MUL  = 13;
  localparam int unsigned OP_ADDC = 14;
  localparam int unsigned OP_SUBC = 15;
  localparam int unsigned OP_JMP  = 16;
  localparam int unsigned OP_BRA  = 17;
  localparam int unsigned OP_CALL = 18;
  localparam int unsigned OP_ADDI = 34;
  localparam int unsigned OP_SUBI = 35;
  localparam int unsigned OP_CMPI = 39;
  localparam int unsigned OP_NEG  = 40;
  localparam int unsigned OP_ABS  = 41;
  localparam int unsigned OP_INC  = 44;
  localparam int unsigned OP_DEC  = 45;
  localparam int unsigned OP_HALT = 64;
  localparam int unsigned OP_WAIT = 65;

  localparam int unsigned CCR_C   = 0;
  localparam int unsigned CCR_N   = 1;
  localparam int unsigned CCR_V   = 2;
  localparam int unsigned CCR_Z   = 3;
  localparam int unsigned CCR_INR = 4;
  localparam int unsigned CCR_NOP = 6;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } sched_state_e;

  function automatic logic is_nop_op(input logic [31:0] op);
    return op inside {OP_NOP, OP_JMP, OP_BRA, OP_CALL, OP_HALT, OP_WAIT};
  endfunction

  function automatic logic is_carry_op(input logic [31:0] op);
    return op inside {OP_ADD, OP_ADDC, OP_ADDI, OP_INC, OP_DEC,
                      OP_SHL, OP_SHR, OP_ROR, OP_ROL};
  endfunction

  function automatic logic is_ovf_op(input logic [31:0] op);
    return op inside {OP_ADD, OP_ADDC, OP_ADDI, OP_INC, OP_DEC,
                      OP_SUB, OP_SUBI, OP_CMPI, OP_NEG, OP_ABS};
  endfunction

  // Decode table: the dense block 0..18 plus the sparse immediate/unary/control ops.
  function automatic logic is_known_op(input logic [31:0] op);
    return (op <= OP_CALL) ||
           (op inside {OP_ADDI, OP_SUBI, OP_CMPI, OP_NEG, OP_ABS, OP_INC, OP_DEC,
                       OP_HALT, OP_WAIT});
  endfunction

endpackage

// File: rtl/alu_req_arbiter.sv
// Two-way request arbiter; fixed priority (req0 first) unless
// ALU_SCHED_ROUND_ROBIN_EN selects an alternating pointer.
module alu_req_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef ALU_SCHED_ROUND_ROBIN_EN
  logic ptr_q;  // 0: req0 preferred, 1: req1 preferred

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= grant[0];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (!ptr_q) begin
        if (req[0])      grant = 2'b01;
        else if (req[1]) grant = 2'b10;
      end else begin
        if (req[1])      grant = 2'b10;
        else if (req[0]) grant = 2'b01;
      end
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, accept};

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu_issue_scheduler.sv
// Shares one combinational ALU between execute (req0) and address generation (req1),
// and owns the CCR. Round-robin arbitration: define ALU_SCHED_ROUND_ROBIN_EN.
module alu_issue_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          req_ready,
  output logic [1:0]          resp_valid,
  output logic [DATA_W-1:0]   resp_rz,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_ra,
  output logic [DATA_W-1:0]   alu_rb,
  output logic [31:0]         alu_ccr,
  output logic                alu_nop_flag,
  input  logic [DATA_W-1:0]   alu_rz,
  input  logic                alu_c,
  input  logic                alu_v,
  input  logic                alu_n,
  input  logic                alu_z,
  output logic [31:0]         ccr_q
);

  sched_state_e        state_q, state_d;
  logic                tag_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q, b_q, rz_q, rz_d;
  logic [31:0]         ccr_d;
  logic [31:0]         op32;
  logic [1:0]          grant;
  logic                arb_en, accept;

  // No grant while reset is asserted so nothing is accepted on a reset edge.
  assign arb_en = (state_q == StIdle) && !rst;
  assign accept = |(req_valid & grant);
  assign op32   = 32'(op_q);

  alu_req_arbiter u_arbiter (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready    = grant;
    resp_valid   = 2'b00;
    resp_rz      = '0;
    alu_op       = '0;
    alu_ra       = '0;
    alu_rb       = '0;
    alu_nop_flag = 1'b0;
    unique case (state_q)
      StIdle: alu_nop_flag = 1'b1;
      StExec: begin
        alu_op       = op_q;
        alu_ra       = a_q;
        alu_rb       = b_q;
        alu_nop_flag = is_nop_op(op32);
      end
      StDone: begin
        resp_valid[tag_q] = 1'b1;
        resp_rz           = rz_q;
      end
      default: ;
    endcase
  end

  assign alu_ccr = ccr_q;

  always_comb begin
    ccr_d = ccr_q;
    rz_d  = alu_rz;
    if (is_nop_op(op32)) begin
      ccr_d[CCR_NOP] = 1'b1;
      rz_d           = '0;
    end else if (!is_known_op(op32)) begin
      ccr_d[CCR_NOP] = 1'b0;
      ccr_d[CCR_INR] = 1'b1;
      ccr_d[CCR_Z]   = 1'b1;
      ccr_d[CCR_N]   = 1'b0;
      rz_d           = '0;
    end else begin
      ccr_d[CCR_NOP] = 1'b0;
      ccr_d[CCR_INR] = 1'b0;
      ccr_d[CCR_Z]   = alu_z;
      ccr_d[CCR_N]   = alu_n;
      if (is_carry_op(op32)) ccr_d[CCR_C] = alu_c;
      if (is_ovf_op(op32))   ccr_d[CCR_V] = alu_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tag_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rz_q    <= '0;
      ccr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && accept) begin
        tag_q <= grant[1];
        op_q  <= grant[1] ? req_op[OP_W +: OP_W]     : req_op[0 +: OP_W];
        a_q   <= grant[1] ? req_a[DATA_W +: DATA_W]  : req_a[0 +: DATA_W];
        b_q   <= grant[1] ? req_b[DATA_W +: DATA_W]  : req_b[0 +: DATA_W];
      end
      if (state_q == StExec) begin
        rz_q  <= rz_d;
        ccr_q <= ccr_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Testbench for alu_issue_scheduler with a behavioural ALU attached to its ALU ports.
module tb_alu_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [63:0] req_op = '0, req_a = '0, req_b = '0;
  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_rz, alu_op, alu_ra, alu_rb, alu_ccr, alu_rz, ccr_q;
  logic        alu_nop_flag, alu_c, alu_v, alu_n, alu_z;

  always #5 clk = ~clk;

  alu_issue_scheduler u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rz      (resp_rz),
    .alu_op       (alu_op),
    .alu_ra       (alu_ra),
    .alu_rb       (alu_rb),
    .alu_ccr      (alu_ccr),
    .alu_nop_flag (alu_nop_flag),
    .alu_rz       (alu_rz),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .ccr_q        (ccr_q)
  );

  // Returns {c, v, n, z, rz}; ROR/ROL rotate by one through the carry.
  function automatic logic [35:0] alu_eval(input logic [31:0] op, a, b, input logic cin);
    logic [32:0] t;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      32'd1: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[31:0];
        c = t[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      32'd2: begin
        t = {1'b0, a} - {1'b0, b};
        r = t[31:0];
        c = t[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      32'd3:  r = a & b;
      32'd4:  r = a | b;
      32'd5:  r = a ^ b;
      32'd11: begin r = {cin, a[31:1]}; c = a[0];  end
      32'd12: begin r = {a[30:0], cin}; c = a[31]; end
      default: begin
        r = a ^ ~b ^ op;
        c = r[0];
        v = r[1];
      end
    endcase
    return {c, v, r[31], (r == 32'd0), r};
  endfunction

  logic [35:0] alu_res;
  always_comb alu_res = alu_eval(alu_op, alu_ra, alu_rb, alu_ccr[0]);
  assign {alu_c, alu_v, alu_n, alu_z, alu_rz} = alu_res;

  function automatic bit nop_class(input logic [31:0] op);
    return op inside {0, 16, 17, 18, 64, 65};
  endfunction
  function automatic bit c_class(input logic [31:0] op);
    return op inside {1, 14, 34, 44, 45, 9, 10, 11, 12};
  endfunction
  function automatic bit v_class(input logic [31:0] op);
    return op inside {1, 14, 34, 44, 45, 2, 35, 39, 40, 41};
  endfunction
  function automatic bit known(input logic [31:0] op);
    return (op <= 18) || (op inside {34, 35, 39, 40, 41, 44, 45, 64, 65});
  endfunction

  typedef struct {
    int          tag;
    logic [31:0] rz;
    logic [31:0] ccr;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] op, a, b, ccr;
    logic        nop;
    int          cyc;
  } exec_t;

  resp_t       rq[$];
  exec_t       eq[$];
  int          errors = 0, checks = 0;
  int          cyc = 0;
  int          next_idle = 0;
  logic [1:0]  pend = 2'b00;
  logic [31:0] p_op[2], p_a[2], p_b[2];
  logic [31:0] ccr_m = '0;
  bit          ptr_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic accept_req(input int i);
    logic [31:0] op, old, nw, rz;
    logic [35:0] r;
    exec_t       e;
    resp_t       s;
    op  = p_op[i];
    old = ccr_m;
    r   = alu_eval(op, p_a[i], p_b[i], old[0]);
    nw  = old;
    rz  = '0;
    if (nop_class(op)) begin
      nw[6] = 1'b1;
    end else if (!known(op)) begin
      nw[6] = 1'b0; nw[4] = 1'b1; nw[3] = 1'b1; nw[1] = 1'b0;
    end else begin
      nw[6] = 1'b0; nw[4] = 1'b0; nw[3] = r[32]; nw[1] = r[33];
      if (c_class(op)) nw[0] = r[35];
      if (v_class(op)) nw[2] = r[34];
      rz = r[31:0];
    end
    ccr_m = nw;
    e.op = op; e.a = p_a[i]; e.b = p_b[i]; e.ccr = old; e.nop = nop_class(op); e.cyc = cyc + 1;
    eq.push_back(e);
    s.tag = i; s.rz = rz; s.ccr = nw; s.cyc = cyc + 2;
    rq.push_back(s);
    pend[i]   = 1'b0;
    next_idle = cyc + 3;
    ptr_m     = (i == 0);
  endtask

  // Called at a negedge: predicts the grant, checks it and records any acceptance.
  task automatic eval_cycle();
    logic [1:0] exp_rdy;
    int         w;
    exp_rdy = 2'b00;
    if (cyc >= next_idle) begin
      chk("idle_nop_flag", alu_nop_flag, 1'b1);
      chk("idle_alu_op", alu_op, 32'd0);
`ifdef ALU_SCHED_ROUND_ROBIN_EN
      if (!ptr_m) w = pend[0] ? 0 : 1;
      else        w = pend[1] ? 1 : 0;
`else
      w = pend[0] ? 0 : 1;
`endif
      if (pend[w]) exp_rdy[w] = 1'b1;
    end
    chk("req_ready", req_ready, exp_rdy);
    if (exp_rdy != 2'b00) accept_req(exp_rdy[1] ? 1 : 0);
  endtask

  task automatic step_cycle();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
    req_valid = pend;
  endtask

  task automatic drive_req(input int i, input logic [31:0] op, a, b);
    p_op[i] = op; p_a[i] = a; p_b[i] = b;
    req_op[i*32 +: 32] = op;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
    pend[i]      = 1'b1;
    req_valid[i] = 1'b1;
  endtask

  task automatic run_until_idle();
    int n;
    n = 0;
    while ((pend != 2'b00 || cyc < next_idle) && n < 60) begin
      step_cycle();
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL run_budget: pending=%b still outstanding after %0d cycles, required done", pend, n);
    end
  endtask

  exec_t m_e;
  resp_t m_r;
  always @(negedge clk) begin
    if (!rst) begin
      if (eq.size() > 0 && eq[0].cyc <= cyc) begin
        m_e = eq.pop_front();
        chk("exec_cycle", cyc, m_e.cyc);
        chk("exec_alu_op", alu_op, m_e.op);
        chk("exec_alu_ra", alu_ra, m_e.a);
        chk("exec_alu_rb", alu_rb, m_e.b);
        chk("exec_alu_ccr", alu_ccr, m_e.ccr);
        chk("exec_nop_flag", alu_nop_flag, m_e.nop);
      end
      if (resp_valid != 2'b00) begin
        if (rq.size() == 0) begin
          chk("resp_unexpected", resp_valid, 2'b00);
        end else begin
          m_r = rq.pop_front();
          chk("resp_tag", resp_valid, 2'b01 << m_r.tag);
          chk("resp_cycle", cyc, m_r.cyc);
          chk("resp_rz", resp_rz, m_r.rz);
          chk("resp_ccr", ccr_q, m_r.ccr);
        end
      end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
        m_r = rq.pop_front();
        chk("resp_missing", resp_valid, 2'b01 << m_r.tag);
      end
    end
  end

  logic [31:0] rand_ops[16];

  initial begin
    rand_ops = '{0, 1, 2, 3, 4, 5, 9, 11, 12, 14, 16, 34, 35, 44, 99, 200};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    next_idle = cyc;
    @(negedge clk);
    chk("rst_ccr", ccr_q, 32'd0);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_resp_rz", resp_rz, 32'd0);
    chk("rst_nop_flag", alu_nop_flag, 1'b1);
    chk("rst_alu_ra", alu_ra, 32'd0);
    chk("rst_req_ready", req_ready, 2'b00);
    @(posedge clk);
    #1;

    drive_req(0, 32'd1, 32'hFFFF_FFFF, 32'd1);
    run_until_idle();
    chk("add_wrap_ccr", ccr_q[3:0], 4'b1001);

    drive_req(1, 32'd11, 32'h2, 32'd0);
    run_until_idle();
    chk("ror_ccr", ccr_q[3:0], 4'b0010);

    drive_req(0, 32'd1, 32'hFFFF_FFFF, 32'd2);
    run_until_idle();
    drive_req(0, 32'd16, 32'h1234, 32'h5678);
    run_until_idle();
    chk("jmp_ccr_low", ccr_q[3:0], 4'b0001);
    chk("jmp_ccr_nop", ccr_q[6], 1'b1);

    drive_req(1, 32'd99, 32'h55, 32'h66);
    run_until_idle();
    chk("bad_op_inr", ccr_q[4], 1'b1);
    drive_req(0, 32'd1, 32'd1, 32'd1);
    run_until_idle();
    chk("add_clears_inr", ccr_q[4], 1'b0);

    drive_req(0, 32'd2, 32'd10, 32'd3);
    drive_req(1, 32'd3, 32'hF0F0, 32'h0FF0);
    run_until_idle();

    // A request raised while busy and withdrawn before IDLE must vanish.
    drive_req(0, 32'd1, 32'd5, 32'd6);
    step_cycle();
    drive_req(1, 32'd3, 32'd7, 32'd7);
    step_cycle();
    pend[1] = 1'b0;
    req_valid[1] = 1'b0;
    run_until_idle();

    for (int k = 0; k < 30; k++) begin
      int m;
      m = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        if (m[i]) drive_req(i, rand_ops[$urandom_range(0, 15)], $urandom, $urandom);
      end
      run_until_idle();
    end

    // Reset during EXEC discards the in-flight op.
    drive_req(0, 32'd1, 32'd7, 32'd8);
    step_cycle();
    rst = 1'b1;
    rq.delete();
    eq.delete();
    ccr_m = '0;
    ptr_m = 1'b0;
    drive_req(0, 32'd1, 32'd1, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    next_idle = cyc;
    @(negedge clk);
    chk("post_rst_ccr", ccr_q, 32'd0);
    chk("post_rst_resp_valid", resp_valid, 2'b00);
    chk("post_rst_ready0", req_ready[0], 1'b1);
    eval_cycle();
    @(posedge clk);
    #1;
    req_valid = pend;
    run_until_idle();

    repeat (4) @(posedge clk);
    #1;
    chk("resp_queue_drained", rq.size(), 0);
    chk("exec_queue_drained", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
